conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
Controls the raster stream out of the image ROM for one frame per start command. Drives ROM addresses, absorbs the ROM's 1-cycle read latency in a small elastic buffer, and presents pixels downstream on a valid/ready interface. Each pixel carries start/end-of-line and start/end-of-frame tags for the 3x3 convolution line buffers. Sits between image_rom and the convolution datapath; a successor to free-running ROM streaming.

Parameters:
IMG_W, 640, pixels per line (>=2)
IMG_H, 960, lines per frame (>=2)
ADDR_W, 32, ROM address width
FIFO_DEPTH, 4, elastic buffer entries (power of 2, >=3)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
start  in  1  1-cycle pulse; begins a frame when idle
abort  in  1  cancel current frame
busy  out  1  high from frame start until done/abort
done  out  1  1-cycle pulse after last pixel handshake
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  8  ROM read data; valid 1 cycle after rom_addr
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accept
m_px  out  8  pixel value
m_sof, m_eof, m_sol, m_eol  out  1 each  tags of current pixel

Behaviour:
- Reset: state IDLE; busy, done, m_valid, m_* tags, m_px = 0; rom_addr = 0; frame_cnt = 0; FIFO empty; x = y = 0.
- States: IDLE -> RUN on start. RUN -> DRAIN when pixel IMG_W*IMG_H-1 is issued. DRAIN -> DONE on handshake of the eof pixel. DONE -> IDLE next cycle. Any state except IDLE -> IDLE on abort.
- busy = (state != IDLE).
- done is high only in DONE. frame_cnt increments in the same cycle as done.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins, stay IDLE.
- Issue: in RUN, issue when (fifo_count + pending) < FIFO_DEPTH.
  - pending = issue registered from the previous cycle.
  - On issue, the ROM returns rom_data for the current rom_addr in the next cycle. That data and its tag are written into the FIFO at the end of that cycle.
  - rom_addr increments the cycle after each issue.
- Tags are computed at issue from x/y counters, delayed 1 cycle alongside the data:
  - sol = (x==0); eol = (x==IMG_W-1)
  - sof = (x==0 && y==0); eof = (x==IMG_W-1 && y==IMG_H-1)
  - x wraps at IMG_W-1 and then increments y.
- Output: m_valid = (fifo_count != 0). m_px and tags come from the FIFO head. A pop happens on m_valid && m_ready.
  - m_px and tags are held stable while m_valid && !m_ready.
- A FIFO write and pop in the same cycle are allowed, and the count is unchanged. The FIFO never overflows by construction.
- Latency: start in cycle 0 -> issue of addr 0 in cycle 1 -> write in cycle 2 -> m_valid in cycle 3.
  - With m_ready held high: 1 pixel/cycle; last pixel in cycle 3+N-1, where N = IMG_W*IMG_H.
  - done is high in cycle 3+N+1.
- Backpressure: if m_ready is low indefinitely, at most FIFO_DEPTH pixels are buffered and issue stalls. Resuming ready loses and duplicates no pixels.
- Abort in cycle t:
  - cycle t+1: FIFO flushed; pending cleared; m_valid = 0; rom_addr = 0; x = y = 0.
  - No done pulse; frame_cnt unchanged.
  - A start in cycle t+1 begins a fresh frame from pixel 0.
- Reset mid-frame: identical to the reset values above.
- Width rules: rom_addr is compared against the constant N-1, computed at ADDR_W bits. x and y counters are $clog2(IMG_W) and $clog2(IMG_H) bits.

Decomposition:
- Shared package conv_pkg:
  - pixel_t (logic [7:0])
  - px_tag_t packed struct {sof, eof, sol, eol}
  - seq_state_t enum {IDLE, RUN, DRAIN, DONE}
- One sub-module px_elastic_fifo: synchronous FIFO of {pixel_t, px_tag_t}, parameter DEPTH, with push/pop/flush/count. It is reusable by the line-buffer stage.

Test Plan:
- Nominal (IMG_W=4, IMG_H=3, ROM data = address): start, m_ready=1 -> m_px 0..11 in cycles 3..14; done only in cycle 16; frame_cnt=1.
- Tag check (same config): sof on px 0; sol on px 0,4,8; eol on px 3,7,11; eof only on px 11; busy high for cycles 1..16.
- Backpressure: m_ready=0 for 20 cycles after start -> m_valid holds px 0 stable; at most 4 issues; then ready=1 -> sequence 0..11 complete, no gaps or duplicates. Random ready toggling gives an identical ordered sequence.
- Abort mid-frame: abort after px 5 handshake -> next cycle m_valid=0, busy=0, rom_addr=0, no done, frame_cnt unchanged; new start streams from px 0.
- Start while busy / start+abort in IDLE: second start during RUN ignored (still 12 pixels, one done); simultaneous start+abort stays IDLE.
- Back-to-back frames and reset: start pulsed in the cycle after done -> second frame correct, frame_cnt=2. rst asserted mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types for the convolution frame sequencer and its
//               elastic pixel buffer (pixel, per-pixel tags, sequencer FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef logic [7:0] pixel_t;

  // Raster position tags travelling with each pixel
  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } px_tag_t;

  // One buffered pixel: value plus its tags
  typedef struct packed {
    pixel_t  px;
    px_tag_t tag;
  } px_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/px_elastic_fifo.sv
`default_nettype none
// ============================================================================
// Module      : px_elastic_fifo
// Description : Synchronous FIFO of tagged pixels with push/pop/flush and an
//               occupancy count. Simultaneous push and pop keep the count.
// Revision    : 1.0 - initial release
// ============================================================================
module px_elastic_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  px_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output px_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  px_entry_t     mem_q [DEPTH];
  px_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_pop;
  logic          w_push;

  // Next-state for storage, pointers and count; flush overrides everything
  always_comb begin
    w_pop    = pop && (count_q != '0);
    w_push   = push && ((count_q != c_full) || w_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_sequencer
// Description : Streams one raster frame from the image ROM per start pulse,
//               absorbs the 1-cycle ROM latency in an elastic buffer and
//               presents tagged pixels on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 960,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_px,
  output logic              m_sof,
  output logic              m_eof,
  output logic              m_sol,
  output logic              m_eol
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     c_x_last    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     c_y_last    = YW'(IMG_H - 1);
  localparam logic [CW:0]       c_depth     = (CW + 1)'(FIFO_DEPTH);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              pending_q, pending_d;
  px_tag_t           tag_q, tag_d;
  logic              eof_hs_q, eof_hs_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              w_flush;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occ;
  px_entry_t         w_head;
  px_entry_t         w_push_data;

  // Reads already in flight count against buffer space so it never overflows
  assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, pending_q};
  assign w_pop       = (w_count != '0) && m_ready;
  assign w_push_data = {rom_data, tag_q};

  px_elastic_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pending_q),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (w_flush),
    .head      (w_head),
    .count     (w_count)
  );

  // Sequencer next-state: issue control, raster counters, tags, completion
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    x_d         = x_q;
    y_d         = y_q;
    pending_d   = 1'b0;
    tag_d       = tag_q;
    eof_hs_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    w_flush     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          rom_addr_d = '0;
          x_d        = '0;
          y_d        = '0;
        end
      end
      RUN: begin
        if (w_occ < c_depth) begin
          pending_d  = 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
          tag_d.sol  = (x_q == '0);
          tag_d.eol  = (x_q == c_x_last);
          tag_d.sof  = (x_q == '0) && (y_q == '0);
          tag_d.eof  = (x_q == c_x_last) && (y_q == c_y_last);
          if (x_q == c_x_last) begin
            x_d = '0;
            y_d = (y_q == c_y_last) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (rom_addr_q == c_last_addr) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The eof handshake is registered, so DONE follows one cycle later
        eof_hs_d = w_pop && w_head.tag.eof;
        if (eof_hs_q) begin
          state_d     = DONE;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats everything, including a simultaneous start in IDLE
    if (abort) begin
      state_d     = IDLE;
      rom_addr_d  = '0;
      x_d         = '0;
      y_d         = '0;
      pending_d   = 1'b0;
      eof_hs_d    = 1'b0;
      frame_cnt_d = frame_cnt_q;
      w_flush     = 1'b1;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pending_q   <= 1'b0;
      tag_q       <= '0;
      eof_hs_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pending_q   <= pending_d;
      tag_q       <= tag_d;
      eof_hs_q    <= eof_hs_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign frame_cnt = frame_cnt_q;
  assign rom_addr  = rom_addr_q;
  assign m_valid   = (w_count != '0);
  // Head is masked when empty so stale entries never leak onto the outputs
  assign m_px      = m_valid ? w_head.px      : '0;
  assign m_sof     = m_valid & w_head.tag.sof;
  assign m_eof     = m_valid & w_head.tag.eof;
  assign m_sol     = m_valid & w_head.tag.sol;
  assign m_eol     = m_valid & w_head.tag.eol;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_sequencer
// Description : Directed self-checking bench for conv_frame_sequencer on a
//               4x3 image with ROM data equal to the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_sequencer;

  localparam int IMG_W      = 4;
  localparam int IMG_H      = 3;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int N          = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_px;
  logic              m_sof;
  logic              m_eof;
  logic              m_sol;
  logic              m_eol;

  int n_checks   = 0;
  int n_errors   = 0;
  int exp_frames = 0;

  // Expected {sof, eof, sol, eol} for pixels 0..11 of a 4x3 raster
  logic [3:0] exp_tag [0:11];

  conv_frame_sequencer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_px      (m_px),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .m_sol     (m_sol),
    .m_eol     (m_eol)
  );

  always #5 clk = ~clk;

  // Image ROM model: registered read, data equals the low address byte
  always @(posedge clk) rom_data <= rom_addr[7:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from a start pulse in cycle 0 until done is seen.
  // mode 0: ready always high, exact cycle timing checked
  // mode 1: ready low for 'stall' cycles, then high
  // mode 2: ready random every cycle
  task automatic run_frame(input string name, input int mode, input int stall, input int restart_at);
    int exp_i;
    int cyc;
    int done_cnt;
    int done_cyc;
    exp_i    = 0;
    cyc      = 0;
    done_cnt = 0;
    done_cyc = -1;
    start    = 1'b1;
    while (done_cnt == 0 && cyc < 300) begin
      if (cyc == restart_at) start = 1'b1;
      case (mode)
        1:       m_ready = (cyc >= stall);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      if (mode == 0) begin
        check_eq({name, " busy"}, 32'(busy), 32'(cyc >= 1 && cyc <= N + 4));
      end
      if (mode == 1 && cyc == stall - 1) begin
        check_eq({name, " stall valid"}, 32'(m_valid), 32'd1);
        check_eq({name, " stall px"}, 32'(m_px), 32'd0);
        check_eq({name, " stall issues"}, rom_addr, 32'(FIFO_DEPTH));
      end
      if (m_valid && m_ready) begin
        if (exp_i < N) begin
          check_eq({name, " px"}, 32'(m_px), 32'(exp_i));
          check_eq({name, " tags"}, 32'({m_sof, m_eof, m_sol, m_eol}), 32'(exp_tag[exp_i]));
          if (mode == 0) check_eq({name, " px cycle"}, 32'(cyc), 32'(3 + exp_i));
        end else begin
          check_eq({name, " extra px count"}, 32'(exp_i + 1), 32'(N));
        end
        exp_i++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      next_cycle();
      start = 1'b0;
      cyc++;
    end
    exp_frames++;
    check_eq({name, " pixel count"}, 32'(exp_i), 32'(N));
    check_eq({name, " done seen"}, 32'(done_cnt), 32'd1);
    check_eq({name, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    if (mode == 0) begin
      check_eq({name, " done cycle"}, 32'(done_cyc), 32'(N + 4));
      check_eq({name, " idle after done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    exp_tag = '{4'b1010, 4'b0000, 4'b0000, 4'b0001,
                4'b0010, 4'b0000, 4'b0000, 4'b0001,
                4'b0010, 4'b0000, 4'b0000, 4'b0101};
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset valid", 32'(m_valid), 32'd0);
    check_eq("reset rom_addr", rom_addr, 32'd0);
    check_eq("reset frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("reset px+tags", 32'({m_px, m_sof, m_eof, m_sol, m_eol}), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Nominal frame, then back-to-back frames with various ready patterns
    run_frame("nominal", 0, 0, -1);
    run_frame("backpressure", 1, 20, -1);
    run_frame("random ready", 2, 0, -1);
    run_frame("start while busy", 0, 0, 5);

    // Abort after pixel 5 handshake (cycle 8), abort asserted in cycle 9
    start   = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 8) begin
        check_eq("abort pre px5 valid", 32'(m_valid), 32'd1);
        check_eq("abort pre px5", 32'(m_px), 32'd5);
      end
      next_cycle();
      start = 1'b0;
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort valid", 32'(m_valid), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort rom_addr", rom_addr, 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    next_cycle();
    run_frame("after abort", 0, 0, -1);

    // Simultaneous start and abort in IDLE: must stay idle
    start = 1'b1;
    abort = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("start+abort busy", 32'(busy), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("start+abort busy later", 32'(busy), 32'd0);
    check_eq("start+abort valid", 32'(m_valid), 32'd0);
    next_cycle();

    // Reset in the middle of a frame
    start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      start = 1'b0;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midreset busy", 32'(busy), 32'd0);
    check_eq("midreset valid", 32'(m_valid), 32'd0);
    check_eq("midreset rom_addr", rom_addr, 32'd0);
    check_eq("midreset frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("midreset px+tags", 32'({m_px, m_sof, m_eof, m_sol, m_eol}), 32'd0);
    next_cycle();
    exp_frames = 0;
    run_frame("after reset", 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
